alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu.sv | 42 ++++
 rtl/rr_arbiter.sv | 33 +++
 rtl/alu_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcodes, output-stage state encoding and the ALU request payload.
package alu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OP_W  = 3;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'b000,
        OP_SLL  = 3'b001,
        OP_SLT  = 3'b010,
        OP_SLTU = 3'b011,
        OP_XOR  = 3'b100,
        OP_SRX  = 3'b101,
        OP_OR   = 3'b110,
        OP_AND  = 3'b111
    } alu_op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Operands and control presented to the shared ALU by the granted requester.
    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        alu_op_e         op_ctrl;
        logic            op_switch;
    } alu_req_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; op_switch selects SUB for ADD and arithmetic shift for SRX.
module alu
    import alu_pkg::*;
(
    input  alu_req_t        req,
    output logic [XLEN-1:0] result
);

    logic [SHAMT_W-1:0] shamt;

    // Operation decode
    always_comb begin
        result = '0;
        shamt  = req.op2[SHAMT_W-1:0];
        case (req.op_ctrl)
            OP_ADD: begin
                if (req.op_switch) begin
                    result = req.op1 - req.op2;
                end else begin
                    result = req.op1 + req.op2;
                end
            end
            OP_SLL:  result = req.op1 << shamt;
            OP_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(req.op1) < $signed(req.op2))};
            OP_SLTU: result = {{(XLEN-1){1'b0}}, (req.op1 < req.op2)};
            OP_XOR:  result = req.op1 ^ req.op2;
            OP_SRX: begin
                // Kept as separate statements so the signed operand is not
                // demoted to unsigned by a mixed-sign conditional.
                if (req.op_switch) begin
                    result = $signed(req.op1) >>> shamt;
                end else begin
                    result = req.op1 >> shamt;
                end
            end
            OP_OR:   result = req.op1 | req.op2;
            OP_AND:  result = req.op1 & req.op2;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant search: first valid requester at or after ptr, wrapping.
module rr_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan N_REQ candidates starting at ptr; the first valid one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((32'(ptr) + k) % N_REQ);
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// N_REQ requesters share one ALU; a one-entry registered output stage
// holds the result and its owner until the owner consumes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ-1:0][XLEN-1:0] req_op1,
    input  logic [N_REQ-1:0][XLEN-1:0] req_op2,
    input  logic [N_REQ-1:0][OP_W-1:0] req_op_ctrl,
    input  logic [N_REQ-1:0]           req_op_switch,
    output logic [N_REQ-1:0]           resp_valid,
    input  logic [N_REQ-1:0]           resp_ready,
    output logic [XLEN-1:0]            resp_result
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    out_state_e       state;
    out_state_e       state_nxt;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] owner_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [XLEN-1:0]  result_nxt;

    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    alu_req_t         alu_in;
    logic [XLEN-1:0]  alu_result;

    logic             drain;
    logic             can_accept;
    logic             accept;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Steer the granted requester's operands into the single ALU.
    always_comb begin
        alu_in.op1       = req_op1[grant_idx];
        alu_in.op2       = req_op2[grant_idx];
        alu_in.op_ctrl   = alu_op_e'(req_op_ctrl[grant_idx]);
        alu_in.op_switch = req_op_switch[grant_idx];
    end

    alu u_alu (
        .req    (alu_in),
        .result (alu_result)
    );

    // Output-stage next state, handshakes and pointer update.
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        ptr_nxt    = ptr;
        result_nxt = resp_result;
        resp_valid = '0;
        req_ready  = '0;
        drain      = 1'b0;
        can_accept = 1'b0;
        accept     = 1'b0;

        for (int unsigned i = 0; i < N_REQ; i++) begin
            resp_valid[i] = !srst && (state == ST_FULL) && (owner == IDX_W'(i));
        end

        drain      = (state == ST_FULL) && resp_valid[owner] && resp_ready[owner];
        can_accept = (state == ST_EMPTY) || drain;

        if (can_accept && !srst) begin
            req_ready = grant;
        end
        accept = |(req_valid & req_ready);

        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (accept) begin
                    state_nxt = ST_FULL;
                end else if (drain) begin
                    state_nxt = ST_EMPTY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase

        if (accept) begin
            owner_nxt  = grant_idx;
            result_nxt = alu_result;
            if (grant_idx == IDX_W'(N_REQ - 1)) begin
                ptr_nxt = '0;
            end else begin
                ptr_nxt = grant_idx + IDX_W'(1);
            end
        end
    end

    // State and result registers; reset wins over accept and drain.
    always_ff @(posedge clk) begin
        if (srst) begin
            state       <= ST_EMPTY;
            owner       <= '0;
            ptr         <= '0;
            resp_result <= '0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            ptr         <= ptr_nxt;
            resp_result <= result_nxt;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with two requesters.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int unsigned N  = 2;
    localparam int unsigned IW = 1;

    logic                clk = 1'b0;
    logic                srst;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N-1:0][31:0]  req_op1;
    logic [N-1:0][31:0]  req_op2;
    logic [N-1:0][2:0]   req_op_ctrl;
    logic [N-1:0]        req_op_switch;
    logic [N-1:0]        resp_valid;
    logic [N-1:0]        resp_ready;
    logic [31:0]         resp_result;

    typedef struct {
        int unsigned idx;
        logic [31:0] res;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [IW-1:0] who;
        logic [2:0]    ctrl;
        logic          sw;
        logic [31:0]   a;
        logic [31:0]   b;
        logic [31:0]   exp;
    } vec_t;
    vec_t vecs[10];

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.N_REQ(N)) dut (
        .clk           (clk),
        .srst          (srst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op1       (req_op1),
        .req_op2       (req_op2),
        .req_op_ctrl   (req_op_ctrl),
        .req_op_switch (req_op_switch),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_result   (resp_result)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] c, input logic s);
        logic [4:0]         sh;
        logic signed [31:0] sa;
        sh = b[4:0];
        sa = $signed(a);
        case (c)
            3'b000: return s ? (a - b) : (a + b);
            3'b001: return a << sh;
            3'b010: return (sa < $signed(b)) ? 32'd1 : 32'd0;
            3'b011: return (a < b) ? 32'd1 : 32'd0;
            3'b100: return a ^ b;
            3'b101: begin
                if (s) begin
                    sa = sa >>> sh;
                    return sa;
                end
                return a >> sh;
            end
            3'b110: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input logic [IW-1:0] i, input logic [2:0] c, input logic s,
                           input logic [31:0] a, input logic [31:0] b);
        req_op_ctrl[i]   = c;
        req_op_switch[i] = s;
        req_op1[i]       = a;
        req_op2[i]       = b;
    endtask

    task automatic rand_req(input logic [IW-1:0] i);
        set_req(i, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    endtask

    // Observe handshakes: pop/compare responses, then push newly accepted ops.
    task automatic monitor();
        sb_t e;
        chk("resp_onehot0", 32'($onehot0(resp_valid)), 32'd1);
        for (int i = 0; i < N; i++) begin
            if (resp_valid[i] && resp_ready[i]) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: response from %0d with none expected", i);
                end else begin
                    e = sb.pop_front();
                    chk("sb_owner", 32'(i), 32'(e.idx));
                    chk("sb_result", resp_result, e.res);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                e.idx = i;
                e.res = ref_alu(req_op1[i], req_op2[i], req_op_ctrl[i], req_op_switch[i]);
                sb.push_back(e);
            end
        end
        if (srst) sb.delete();
    endtask

    task automatic settle();
        #2;
        monitor();
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] oh;
        logic [N-1:0] acc;

        vecs[0] = '{who: 1'b0, ctrl: OP_ADD,  sw: 1'b0, a: 32'hFFFF_FFEC, b: 32'd2,         exp: 32'hFFFF_FFEE};
        vecs[1] = '{who: 1'b1, ctrl: OP_ADD,  sw: 1'b1, a: 32'd5,         b: 32'd7,         exp: 32'hFFFF_FFFE};
        vecs[2] = '{who: 1'b0, ctrl: OP_SLL,  sw: 1'b0, a: 32'h0000_00F1, b: 32'h0000_0024, exp: 32'h0000_0F10};
        vecs[3] = '{who: 1'b1, ctrl: OP_SLT,  sw: 1'b0, a: 32'hFFFF_FFFF, b: 32'd1,         exp: 32'd1};
        vecs[4] = '{who: 1'b0, ctrl: OP_SLTU, sw: 1'b0, a: 32'hFFFF_FFFF, b: 32'd1,         exp: 32'd0};
        vecs[5] = '{who: 1'b1, ctrl: OP_XOR,  sw: 1'b0, a: 32'hF0F0_F0F0, b: 32'hFF00_FF00, exp: 32'h0FF0_0FF0};
        vecs[6] = '{who: 1'b0, ctrl: OP_SRX,  sw: 1'b1, a: 32'h8000_0000, b: 32'd4,         exp: 32'hF800_0000};
        vecs[7] = '{who: 1'b1, ctrl: OP_SRX,  sw: 1'b0, a: 32'h8000_0000, b: 32'd4,         exp: 32'h0800_0000};
        vecs[8] = '{who: 1'b0, ctrl: OP_OR,   sw: 1'b0, a: 32'hF0F0_F0F0, b: 32'h0F00_0F00, exp: 32'hFFF0_FFF0};
        vecs[9] = '{who: 1'b1, ctrl: OP_AND,  sw: 1'b0, a: 32'hF0F0_F0F0, b: 32'hFF00_FF00, exp: 32'hF000_F000};

        srst          = 1'b1;
        req_valid     = '0;
        resp_ready    = '0;
        req_op1       = '0;
        req_op2       = '0;
        req_op_ctrl   = '0;
        req_op_switch = '0;
        repeat (2) @(negedge clk);

        // Reset gating with both requesters and both consumers active.
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        set_req(1'b0, OP_ADD, 1'b0, 32'hFFFF_FFEC, 32'd2);
        set_req(1'b1, OP_ADD, 1'b1, 32'd5, 32'd7);
        settle();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        next();

        // First cycle after reset: req 0 then req 1.
        srst = 1'b0;
        settle();
        chk("post_rst_result", resp_result, 32'd0);
        chk("first_grant", 32'(req_ready), 32'b01);
        next();
        req_valid = 2'b10;
        settle();
        chk("lat1_valid", 32'(resp_valid), 32'b01);
        chk("lat1_result", resp_result, 32'hFFFF_FFEE);
        chk("second_grant", 32'(req_ready), 32'b10);
        next();
        req_valid = '0;
        settle();
        chk("sub_valid", 32'(resp_valid), 32'b10);
        chk("sub_result", resp_result, 32'hFFFF_FFFE);
        next();
        settle();
        chk("idle_valid", 32'(resp_valid), 32'd0);
        chk("idle_hold", resp_result, 32'hFFFF_FFFE);
        next();

        // Table of single-requester operations.
        for (int k = 0; k < 10; k++) begin
            oh = '0;
            oh[vecs[k].who] = 1'b1;
            set_req(vecs[k].who, vecs[k].ctrl, vecs[k].sw, vecs[k].a, vecs[k].b);
            req_valid  = oh;
            resp_ready = 2'b11;
            settle();
            chk($sformatf("vec%0d_ready", k), 32'(req_ready), 32'(oh));
            next();
            req_valid = '0;
            settle();
            chk($sformatf("vec%0d_valid", k), 32'(resp_valid), 32'(oh));
            chk($sformatf("vec%0d_result", k), resp_result, vecs[k].exp);
            next();
        end

        // Backpressure, non-owner ready ignored, then drain + accept together.
        set_req(1'b0, OP_ADD, 1'b0, 32'd100, 32'd23);
        req_valid  = 2'b01;
        resp_ready = 2'b00;
        settle();
        chk("bp_accept", 32'(req_ready), 32'b01);
        next();
        set_req(1'b1, OP_XOR, 1'b0, 32'hAAAA_5555, 32'hFFFF_0000);
        req_valid = 2'b10;
        for (int k = 0; k < 3; k++) begin
            resp_ready = (k == 1) ? 2'b10 : 2'b00;
            settle();
            chk("stall_valid", 32'(resp_valid), 32'b01);
            chk("stall_result", resp_result, 32'd123);
            chk("stall_ready", 32'(req_ready), 32'd0);
            next();
        end
        resp_ready = 2'b01;
        settle();
        chk("drain_accept_ready", 32'(req_ready), 32'b10);
        next();
        req_valid  = '0;
        resp_ready = 2'b11;
        settle();
        chk("bp_second_valid", 32'(resp_valid), 32'b10);
        chk("bp_second_result", resp_result, 32'h5555_5555);
        next();

        // Fairness and full throughput with both requesters always valid.
        rand_req(1'b0);
        rand_req(1'b1);
        req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            settle();
            chk("fair_grant", 32'(req_ready), (k % 2 == 0) ? 32'b01 : 32'b10);
            if (k == 0) chk("fair_resp0", 32'(resp_valid), 32'd0);
            else        chk("fair_resp", 32'(resp_valid), (k % 2 == 1) ? 32'b01 : 32'b10);
            acc = req_ready & req_valid;
            next();
            for (int i = 0; i < N; i++) begin
                if (acc[i]) rand_req(IW'(i));
            end
        end
        req_valid = '0;
        settle();
        chk("fair_last_valid", 32'(resp_valid), 32'b10);
        next();
        settle();
        chk("fair_empty", 32'(resp_valid), 32'd0);
        next();

        // Reset while FULL discards the held result and clears ptr.
        set_req(1'b0, OP_ADD, 1'b0, 32'd9, 32'd9);
        req_valid  = 2'b01;
        resp_ready = 2'b00;
        settle();
        chk("rf_accept", 32'(req_ready), 32'b01);
        next();
        req_valid = '0;
        settle();
        chk("rf_full", 32'(resp_valid), 32'b01);
        next();
        srst       = 1'b1;
        req_valid  = 2'b11;
        resp_ready = 2'b01;
        set_req(1'b0, OP_ADD, 1'b0, 32'd1, 32'd1);
        set_req(1'b1, OP_OR, 1'b0, 32'h10, 32'h01);
        settle();
        chk("rf_rst_ready", 32'(req_ready), 32'd0);
        chk("rf_rst_valid", 32'(resp_valid), 32'd0);
        next();
        srst       = 1'b0;
        resp_ready = 2'b11;
        settle();
        chk("rf_discarded", 32'(resp_valid), 32'd0);
        chk("rf_result_clr", resp_result, 32'd0);
        chk("rf_grant0", 32'(req_ready), 32'b01);
        next();
        req_valid = '0;
        settle();
        chk("rf_resp_valid", 32'(resp_valid), 32'b01);
        chk("rf_resp_result", resp_result, 32'd2);
        next();
        settle();
        next();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
